// File: rtl/parking_entry_client.sv
`default_nettype none
// ============================================================================
//  Module      : parking_entry_client
//  Description : Car-side driver for the parking gate controller. Raises the
//                entry sensor on an arrival, presents a latched password,
//                retries with a blanking gap on timeout and releases the
//                sensor once the car has driven through.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_entry_client #(
    parameter int SETTLE_CYC  = 4,
    parameter int GAP_CYC     = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int DRIVE_CYC   = 8,
    parameter int MAX_TRY     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive,
    input  logic [3:0] key,
    input  logic       gate_open,
    output logic       sensor,
    output logic [3:0] pass,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] tries
);

    // One shared counter serves every timed state, so it is sized for the
    // longest of the cycle parameters with one bit of headroom.
    localparam int C_MAX_AB  = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int C_MAX_CD  = (TIMEOUT_CYC > DRIVE_CYC) ? TIMEOUT_CYC : DRIVE_CYC;
    localparam int C_MAX_CYC = (C_MAX_AB > C_MAX_CD) ? C_MAX_AB : C_MAX_CD;
    localparam int CNT_W     = $clog2(C_MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_DRIVE_LAST   = CNT_W'(DRIVE_CYC - 1);
    localparam logic [3:0]       C_MAX_TRY      = 4'(MAX_TRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_PRESENT = 3'd2,
        S_GAP     = 3'd3,
        S_PASSING = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       key_q,   key_d;
    logic             sensor_q, sensor_d;
    logic [3:0]       pass_q,  pass_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             fail_q,  fail_d;
    logic [3:0]       tries_q, tries_d;

    assign sensor = sensor_q;
    assign pass   = pass_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign fail   = fail_q;
    assign tries  = tries_q;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        sensor_d = sensor_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fail_d   = 1'b0;
        tries_d  = tries_q;

        case (state_q)
            S_IDLE: begin
                if (arrive) begin
                    key_d    = key;
                    tries_d  = 4'd1;
                    busy_d   = 1'b1;
                    sensor_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    cnt_d   = '0;
                    pass_d  = key_q;
                    state_d = S_PRESENT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PRESENT: begin
                // An open gate takes priority over a timeout in the same cycle.
                if (gate_open) begin
                    cnt_d   = '0;
                    pass_d  = 4'b0000;
                    state_d = S_PASSING;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    cnt_d  = '0;
                    pass_d = 4'b0000;
                    if (tries_q == C_MAX_TRY) begin
                        sensor_d = 1'b0;
                        fail_d   = 1'b1;
                        state_d  = S_FINISH;
                    end else begin
                        tries_d = tries_q + 4'd1;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    cnt_d   = '0;
                    pass_d  = key_q;
                    state_d = S_PRESENT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PASSING: begin
                // Fixed drive-through time regardless of gate_open afterwards.
                if (cnt_q == C_DRIVE_LAST) begin
                    cnt_d    = '0;
                    sensor_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                sensor_d = 1'b0;
                pass_d   = 4'b0000;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any
    // session without producing a done or fail pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            key_q    <= 4'b0000;
            sensor_q <= 1'b0;
            pass_q   <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            tries_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            sensor_q <= sensor_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            tries_q  <= tries_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking_entry_client.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_entry_client
//  Description : Self-checking bench for parking_entry_client. Expected
//                outputs come from a timeline model: attempt windows,
//                gap spans and the drive-through interval are computed
//                arithmetically from the timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_entry_client;

    localparam int SETTLE_CYC  = 4;
    localparam int GAP_CYC     = 3;
    localparam int TIMEOUT_CYC = 16;
    localparam int DRIVE_CYC   = 8;
    localparam int MAX_TRY     = 3;

    logic       clk;
    logic       rst;
    logic       arrive;
    logic [3:0] key;
    logic       gate_open;
    logic       sensor;
    logic [3:0] pass;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] tries;

    int checks = 0;
    int errors = 0;

    // Session plan: gate_open per relative cycle (cycle 0 = arrive cycle).
    logic [127:0] g_vec;
    logic [3:0]   s_key;
    logic [3:0]   prev_tries;
    int           open_n;
    int           last_att;
    int           fin_n;

    parking_entry_client #(
        .SETTLE_CYC (SETTLE_CYC),
        .GAP_CYC    (GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .DRIVE_CYC  (DRIVE_CYC),
        .MAX_TRY    (MAX_TRY)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .arrive   (arrive),
        .key      (key),
        .gate_open(gate_open),
        .sensor   (sensor),
        .pass     (pass),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .tries    (tries)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // First cycle in which attempt k shows the password.
    function automatic int ws(int k);
        return SETTLE_CYC + 1 + (k - 1) * (TIMEOUT_CYC + GAP_CYC);
    endfunction

    // Find the first gate_open that falls inside an attempt window.
    function automatic void plan();
        open_n   = -1;
        last_att = MAX_TRY;
        for (int k = 1; k <= MAX_TRY && open_n < 0; k++)
            for (int n = ws(k); n < ws(k) + TIMEOUT_CYC && open_n < 0; n++)
                if (g_vec[n]) begin
                    open_n   = n;
                    last_att = k;
                end
        fin_n = (open_n >= 0) ? open_n + DRIVE_CYC + 1 : ws(MAX_TRY) + TIMEOUT_CYC;
    endfunction

    // Expected {sensor, pass, busy, done, fail, tries} during relative cycle n.
    function automatic logic [11:0] expect_at(int n);
        logic       sen, bsy, dn, fl, in_win;
        logic [3:0] ps;
        int         tr;
        if (n == 0) return {1'b0, 4'b0000, 3'b000, prev_tries};
        sen    = (n < fin_n);
        bsy    = (n <= fin_n);
        dn     = (n == fin_n) && (open_n >= 0);
        fl     = (n == fin_n) && (open_n < 0);
        in_win = 1'b0;
        for (int k = 1; k <= last_att; k++)
            if (n >= ws(k) && n < ws(k) + TIMEOUT_CYC) in_win = 1'b1;
        ps = (in_win && (open_n < 0 || n <= open_n)) ? s_key : 4'b0000;
        tr = 1;
        for (int k = 1; k < MAX_TRY; k++)
            if (n >= ws(k) + TIMEOUT_CYC) tr++;
        if (tr > last_att) tr = last_att;
        return {sen, ps, bsy, dn, fl, 4'(tr)};
    endfunction

    // Drive one cycle of inputs and sample the outputs mid-cycle.
    task automatic cycle(input logic a, input logic [3:0] k, input logic go,
                         output logic [11:0] obs);
        arrive    = a;
        key       = k;
        gate_open = go;
        @(negedge clk);
        obs = {sensor, pass, busy, done, fail, tries};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        rst = 1'b1; arrive = 1'b1; key = 4'hF; gate_open = 1'b1;
        @(negedge clk);
        obs = {sensor, pass, busy, done, fail, tries};
        checks++;
        if (obs !== 12'b0) begin
            errors++;
            $display("FAIL reset_hold got %b expected %b", obs, 12'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0; arrive = 1'b0; gate_open = 1'b0;
        @(negedge clk);
        obs = {sensor, pass, busy, done, fail, tries};
        checks++;
        if (obs !== 12'b0) begin
            errors++;
            $display("FAIL reset_release got %b expected %b", obs, 12'b0);
        end
        @(posedge clk); #1;
        prev_tries = 4'd0;
    endtask

    // Directed sessions: normal entry, full failure, success on attempt 2,
    // open on the exact timeout cycle, and ignored arrive/key/gate_open.
    task automatic test_directed_sessions();
        logic [11:0] obs, exp;
        logic        noise;
        for (int sc = 0; sc < 5; sc++) begin
            g_vec = '0;
            noise = 1'b0;
            s_key = 4'($urandom);
            case (sc)
                0: begin s_key = 4'b1011; g_vec[ws(1) + 5] = 1'b1; end
                1: ;
                2: g_vec[ws(2) + 2] = 1'b1;
                3: g_vec[ws(1) + TIMEOUT_CYC - 1] = 1'b1;
                default: begin
                    noise = 1'b1;
                    g_vec[2] = 1'b1;
                    g_vec[3] = 1'b1;
                    for (int i = 0; i < GAP_CYC; i++) g_vec[ws(1) + TIMEOUT_CYC + i] = 1'b1;
                    g_vec[ws(2) + 6] = 1'b1;
                end
            endcase
            plan();
            for (int n = 0; n <= fin_n; n++) begin
                cycle(n == 0 ? 1'b1 : (noise ? 1'($urandom) : 1'b0),
                      (n == 0 || !noise) ? s_key : 4'($urandom), g_vec[n], obs);
                exp = expect_at(n);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL directed_%0d cyc %0d got %b expected %b", sc, n, obs, exp);
                end
            end
            prev_tries = 4'(last_att);
        end
    endtask

    // Reset in the middle of an attempt window aborts without a pulse.
    task automatic test_reset_abort();
        logic [11:0] obs, exp;
        g_vec = '0;
        s_key = 4'($urandom);
        plan();
        for (int n = 0; n <= ws(1) + 3; n++) begin
            cycle(n == 0, n == 0 ? s_key : 4'($urandom), 1'b0, obs);
            exp = expect_at(n);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_pre cyc %0d got %b expected %b", n, obs, exp);
            end
        end
        rst = 1'b1;
        cycle(1'b0, 4'($urandom), 1'b0, obs);
        exp = expect_at(ws(1) + 4);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL abort_edge got %b expected %b", obs, exp);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'($urandom), 1'($urandom), obs);
            checks++;
            if (obs !== 12'b0) begin
                errors++;
                $display("FAIL abort_after %0d got %b expected %b", i, obs, 12'b0);
            end
        end
        prev_tries = 4'd0;
    endtask

    // Random sessions, often started the cycle right after FINISH.
    task automatic test_back_to_back();
        logic [11:0] obs, exp;
        int          dens, idle;
        for (int s = 0; s < 30; s++) begin
            dens = $urandom_range(6, 60);
            for (int n = 0; n < 128; n++) g_vec[n] = ($urandom_range(0, dens - 1) == 0);
            s_key = 4'($urandom);
            plan();
            for (int n = 0; n <= fin_n; n++) begin
                cycle(n == 0 ? 1'b1 : 1'($urandom), n == 0 ? s_key : 4'($urandom),
                      g_vec[n], obs);
                exp = expect_at(n);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random_%0d cyc %0d got %b expected %b", s, n, obs, exp);
                end
            end
            prev_tries = 4'(last_att);
            idle = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            for (int i = 0; i < idle; i++) begin
                cycle(1'b0, 4'($urandom), 1'($urandom), obs);
                exp = expect_at(0);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL idle_%0d got %b expected %b", s, obs, exp);
                end
            end
        end
        cycle(1'b0, 4'b0000, 1'b0, obs);
        exp = expect_at(0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL final_idle got %b expected %b", obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        arrive     = 1'b0;
        key        = 4'b0000;
        gate_open  = 1'b0;
        prev_tries = 4'd0;
        g_vec      = '0;
        s_key      = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed_sessions();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
